// File: rtl/fsm_flow_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsm_flow_pkg
// Brief    : One-hot state encoding and default thresholds for fsm_flow_ctrl.
// Revision : 1.0
// ============================================================================
package fsm_flow_pkg;

    localparam int S_RESET  = 0;
    localparam int S_INIT   = 1;
    localparam int S_IDLE   = 2;
    localparam int S_ACTIVE = 3;
    localparam int S_ERROR  = 4;

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    function automatic int DEF_AF(input int depth);
        return depth - 1;
    endfunction

    function automatic int DEF_AE();
        return 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_ch_pause.sv
`default_nettype none
// ============================================================================
// Module   : fsm_ch_pause
// Brief    : Single-channel pause register with almost-full/almost-empty hysteresis.
// Revision : 1.0
// ============================================================================
module fsm_ch_pause #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] af_th,
    input  logic [CNT_W-1:0] ae_th,
    input  logic             enable,
    input  logic             force_set,
    input  logic             force_clr,
    output logic             pause_i
);

    logic r_pause;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pause <= 1'b0;
        end else if (force_set) begin
            r_pause <= 1'b1;
        end else if (force_clr) begin
            r_pause <= 1'b0;
        end else if (enable) begin
            // Between the thresholds the previous pause level is held.
            if (count >= af_th) begin
                r_pause <= 1'b1;
            end else if (count <= ae_th) begin
                r_pause <= 1'b0;
            end
        end
    end

    assign pause_i = r_pause;

endmodule
`default_nettype wire

// File: rtl/fsm_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fsm_flow_ctrl
// Brief    : Multi-channel FIFO flow control with hysteresis pause and sticky errors.
// Revision : 1.0
// ============================================================================
module fsm_flow_ctrl
    import fsm_flow_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [CNT_W-1:0]        th_almost_full,
    input  logic [CNT_W-1:0]        th_almost_empty,
    input  logic [NUM_CH*CNT_W-1:0] fifo_count,
    input  logic [NUM_CH-1:0]       fifo_overflow,
    output logic [NUM_CH-1:0]       pause,
    output logic [NUM_CH-1:0]       error_ch,
    output logic [4:0]              state,
    output logic                    idle_out,
    output logic [CNT_W-1:0]        af_th,
    output logic [CNT_W-1:0]        ae_th
);

    localparam logic [CNT_W-1:0] c_depth  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_def_af = CNT_W'(DEF_AF(DEPTH));
    localparam logic [CNT_W-1:0] c_def_ae = CNT_W'(DEF_AE());

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_af_th;
    logic [CNT_W-1:0]  r_ae_th;
    logic [NUM_CH-1:0] r_error_ch;
    logic              r_idle;
    logic              w_any_nz;
    logic              w_any_ovf;
    logic              w_th_valid;
    logic              w_en;
    logic              w_set;
    logic              w_clr;

    assign w_any_nz   = |fifo_count;
    assign w_any_ovf  = |fifo_overflow;
    assign w_th_valid = (th_almost_empty < th_almost_full) && (th_almost_full <= c_depth);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RESET:  w_next = ST_INIT;
            ST_INIT:   w_next = init ? ST_INIT : ST_IDLE;
            ST_IDLE: begin
                if (init) begin
                    w_next = ST_INIT;
                end else if (w_any_nz) begin
                    w_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (init) begin
                    w_next = ST_INIT;
                end else if (!w_any_nz) begin
                    w_next = ST_IDLE;
                end
            end
            ST_ERROR:  w_next = ST_ERROR;
            default:   w_next = ST_RESET;
        endcase
        // Overflow outranks init and emptiness; RESET is the only state that ignores it.
        if (r_state != ST_RESET && w_any_ovf) begin
            w_next = ST_ERROR;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_RESET;
            r_af_th    <= c_def_af;
            r_ae_th    <= c_def_ae;
            r_error_ch <= '0;
            r_idle     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idle  <= (w_next == ST_IDLE);
            if (r_state != ST_RESET) begin
                r_error_ch <= r_error_ch | fifo_overflow;
            end
            if (r_state == ST_INIT && w_th_valid) begin
                r_af_th <= th_almost_full;
                r_ae_th <= th_almost_empty;
            end
        end
    end

    // Pause follows the state being entered so it lines up with the registered state.
    assign w_en  = (w_next == ST_ACTIVE);
    assign w_set = (w_next == ST_ERROR);
    assign w_clr = !(w_en || w_set);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            fsm_ch_pause #(
                .CNT_W (CNT_W)
            ) u_ch_pause (
                .clk       (clk),
                .reset     (reset),
                .count     (fifo_count[gi*CNT_W +: CNT_W]),
                .af_th     (r_af_th),
                .ae_th     (r_ae_th),
                .enable    (w_en),
                .force_set (w_set),
                .force_clr (w_clr),
                .pause_i   (pause[gi])
            );
        end
    endgenerate

    assign state    = r_state;
    assign idle_out = r_idle;
    assign error_ch = r_error_ch;
    assign af_th    = r_af_th;
    assign ae_th    = r_ae_th;

endmodule
`default_nettype wire
